// File: rtl/rc4_decrypt.sv
// ============================================================================
// Module   : rc4_decrypt
// Brief    : RC4 PRGA stage - XORs keystream with encrypted ROM, writes RAM,
//            aborts on the first byte that is not lowercase or space.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rc4_decrypt #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        s_q,
  input  logic [7:0]        e_q,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_write,
  output logic [MSG_AW-1:0] e_address,
  output logic [MSG_AW-1:0] d_address,
  output logic [7:0]        d_data,
  output logic              d_write,
  output logic              done,
  output logic              fail
);

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);
  localparam logic [MSG_AW-1:0] K_ONE  = MSG_AW'(1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    INC    = 4'd1,
    RD_I   = 4'd2,
    WAIT_I = 4'd3,
    CAP_I  = 4'd4,
    RD_J   = 4'd5,
    WAIT_J = 4'd6,
    CAP_J  = 4'd7,
    WR_I   = 4'd8,
    WR_J   = 4'd9,
    RD_F   = 4'd10,
    WAIT_F = 4'd11,
    CAP_F  = 4'd12,
    WR_D   = 4'd13,
    DONE   = 4'd14
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        i_q, i_d;
  logic [7:0]        j_q, j_d;
  logic [MSG_AW-1:0] k_q, k_d;
  logic [7:0]        si_q, si_d;
  logic [7:0]        sj_q, sj_d;
  logic [7:0]        f_q, f_d;
  logic              fail_q, fail_d;
  logic              f_printable;

  assign f_printable = (f_q == 8'h20) || ((f_q >= 8'h61) && (f_q <= 8'h7A));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= '0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      f_q     <= 8'd0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      f_q     <= f_d;
      fail_q  <= fail_d;
    end
  end

  // Read addresses stay asserted through WAIT and CAP so a registered-address
  // memory sees a stable address for its whole read latency.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    si_d      = si_q;
    sj_d      = sj_q;
    f_d       = f_q;
    fail_d    = fail_q;
    s_address = 8'd0;
    s_data    = 8'd0;
    s_write   = 1'b0;
    d_data    = 8'd0;
    d_write   = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = '0;
          fail_d  = 1'b0;
          state_d = INC;
        end
      end
      INC: begin
        i_d     = i_q + 8'd1;
        state_d = RD_I;
      end
      RD_I: begin
        s_address = i_q;
        state_d   = WAIT_I;
      end
      WAIT_I: begin
        s_address = i_q;
        state_d   = CAP_I;
      end
      CAP_I: begin
        s_address = i_q;
        si_d      = s_q;
        j_d       = j_q + s_q;
        state_d   = RD_J;
      end
      RD_J: begin
        s_address = j_q;
        state_d   = WAIT_J;
      end
      WAIT_J: begin
        s_address = j_q;
        state_d   = CAP_J;
      end
      CAP_J: begin
        s_address = j_q;
        sj_d      = s_q;
        state_d   = WR_I;
      end
      WR_I: begin
        s_address = i_q;
        s_data    = sj_q;
        s_write   = 1'b1;
        state_d   = WR_J;
      end
      WR_J: begin
        s_address = j_q;
        s_data    = si_q;
        s_write   = 1'b1;
        state_d   = RD_F;
      end
      RD_F: begin
        s_address = si_q + sj_q;
        state_d   = WAIT_F;
      end
      WAIT_F: begin
        s_address = si_q + sj_q;
        state_d   = CAP_F;
      end
      CAP_F: begin
        s_address = si_q + sj_q;
        f_d       = s_q ^ e_q;
        state_d   = WR_D;
      end
      WR_D: begin
        d_data  = f_q;
        d_write = 1'b1;
        if (!f_printable) begin
          fail_d  = 1'b1;
          state_d = DONE;
        end else if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + K_ONE;
          state_d = INC;
        end
      end
      DONE: begin
        done = 1'b1;
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign e_address = k_q;
  assign d_address = k_q;
  assign fail      = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_rc4_decrypt.sv
// ============================================================================
// Module   : tb_rc4_decrypt
// Brief    : Directed self-checking bench for rc4_decrypt with memory models.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rc4_decrypt;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] s_q;
  logic [7:0] e_q;
  logic [7:0] s_address;
  logic [7:0] s_data;
  logic       s_write;
  logic [4:0] e_address;
  logic [4:0] d_address;
  logic [7:0] d_data;
  logic       d_write;
  logic       done;
  logic       fail;

  rc4_decrypt #(.MSG_LEN(32), .MSG_AW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .s_q(s_q), .e_q(e_q),
    .s_address(s_address), .s_data(s_data), .s_write(s_write),
    .e_address(e_address), .d_address(d_address), .d_data(d_data),
    .d_write(d_write), .done(done), .fail(fail)
  );

  always #5 clk = ~clk;

  // Memory models: two-cycle synchronous read (registered address + output).
  logic [7:0] smem [0:255];
  logic [7:0] emem [0:31];
  logic [7:0] dmem [0:31];
  logic [7:0] s_r1 = 8'd0;
  logic [7:0] e_r1 = 8'd0;
  logic       s_init = 1'b0;
  int         dcount = 0;
  int         swcount = 0;
  logic       both_seen = 1'b0;

  always @(posedge clk) begin
    if (s_init) begin
      for (int n = 0; n < 256; n++) smem[n] <= 8'(n);
    end else if (s_write) begin
      smem[s_address] <= s_data;
    end
    s_r1 <= smem[s_address];
    s_q  <= s_r1;
    e_r1 <= emem[e_address];
    e_q  <= e_r1;
    if (d_write) begin
      dmem[d_address] <= d_data;
      dcount <= dcount + 1;
    end
    if (s_write) swcount <= swcount + 1;
  end

  always @(negedge clk) if (s_write && d_write) both_seen <= 1'b1;

  // Independent RC4 PRGA reference over identity S.
  logic [7:0] ks_m   [0:31];
  logic [7:0] sfin_m [0:255];

  task automatic compute_model();
    logic [7:0] s [0:255];
    logic [7:0] i, j, t, idx;
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    i = 8'd0;
    j = 8'd0;
    for (int k = 0; k < 32; k++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      idx = s[i] + s[j];
      ks_m[k] = s[idx];
    end
    for (int n = 0; n < 256; n++) sfin_m[n] = s[n];
  endtask

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_identity();
    s_init = 1'b1;
    tick();
    s_init = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done && cyc < limit);
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc, c, base, bad, swbase;

    compute_model();
    reset = 1'b1;
    start = 1'b0;
    for (int n = 0; n < 32; n++) emem[n] = 8'h61;
    tick();
    tick();
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fail", {31'd0, fail}, 32'd0);
    check("rst_wr", {30'd0, s_write, d_write}, 32'd0);
    check("rst_addr", {8'd0, s_address, 3'd0, e_address, 3'd0, d_address}, 32'd0);
    check("rst_data", {16'd0, s_data, d_data}, 32'd0);
    reset = 1'b0;
    load_identity();

    // Bytes 0 and 1 with identity S: keystream 02, 05; byte 1 decrypts to 60.
    emem[0] = 8'h63;
    emem[1] = 8'h65;
    base = dcount;
    start = 1'b1;
    cyc = 0;
    do begin tick(); cyc++; end while (!d_write && cyc < 40);
    check("first_dwrite_lat", cyc, 32'd13);
    check("first_ddata", {24'd0, d_data}, 32'h61);
    wait_done(60, c);
    check("fail_run_cycles", cyc + c, 32'd27);
    check("fail_run_fail", {31'd0, fail}, 32'd1);
    check("fail_run_writes", dcount - base, 32'd2);
    check("dec0", {24'd0, dmem[0]}, 32'h61);
    check("dec1", {24'd0, dmem[1]}, 32'h60);
    check("s1", {24'd0, smem[1]}, 32'd1);
    check("s2s3", {16'd0, smem[2], smem[3]}, 32'h0302);
    start = 1'b0;
    tick();

    // Full pass; start dropped early must not stop the run.
    for (int n = 0; n < 32; n++) emem[n] = ks_m[n] ^ 8'h61;
    load_identity();
    base = dcount;
    start = 1'b1;
    cyc = 0;
    repeat (3) begin tick(); cyc++; end
    start = 1'b0;
    wait_done(600, c);
    check("full_cycles", cyc + c, 32'd417);
    check("full_fail", {31'd0, fail}, 32'd0);
    check("full_writes", dcount - base, 32'd32);
    tick();
    bad = 0;
    for (int n = 0; n < 32; n++) if (dmem[n] !== 8'h61) bad++;
    check("full_dec_bad", bad, 32'd0);
    bad = 0;
    for (int n = 0; n < 256; n++) if (smem[n] !== sfin_m[n]) bad++;
    check("full_smem_bad", bad, 32'd0);

    // Last byte = space: passes.
    emem[31] = ks_m[31] ^ 8'h20;
    load_identity();
    start = 1'b1;
    wait_done(600, c);
    check("space_fail", {31'd0, fail}, 32'd0);
    tick();
    check("space_dec31", {24'd0, dmem[31]}, 32'h20);
    start = 1'b0;
    tick();

    // Last byte = 7B: fails after 32 writes; then DONE hold and restart.
    emem[31] = ks_m[31] ^ 8'h7B;
    load_identity();
    base = dcount;
    start = 1'b1;
    wait_done(600, c);
    check("brace_cycles", c, 32'd417);
    check("brace_fail", {31'd0, fail}, 32'd1);
    tick();
    check("brace_writes", dcount - base, 32'd32);
    repeat (4) tick();
    check("done_hold", {31'd0, done}, 32'd1);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check("restart_done_low", {31'd0, done}, 32'd0);
    tick();
    check("restart_rd_i", {24'd0, s_address}, 32'd1);
    reset = 1'b1;
    start = 1'b0;
    tick();
    reset = 1'b0;

    // Reset during WR_I of byte 5, then restart from a clean state.
    emem[31] = ks_m[31] ^ 8'h61;
    load_identity();
    base = dcount;
    start = 1'b1;
    cyc = 0;
    while ((dcount - base) < 5 && cyc < 200) begin tick(); cyc++; end
    while (!s_write && cyc < 220) begin tick(); cyc++; end
    check("wr_i_byte5_addr", {24'd0, s_address}, 32'd6);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_outputs", {s_address, s_data, d_data, 3'd0, d_address, 4'd0},
          32'd0);
    check("midrst_flags", {28'd0, s_write, d_write, done, fail}, 32'd0);
    start = 1'b0;
    swbase = swcount;
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    check("no_sw_after_rst", swcount - swbase, 32'd0);
    load_identity();
    start = 1'b1;
    cyc = 0;
    repeat (2) begin tick(); cyc++; end
    check("restart_i", {24'd0, s_address}, 32'd1);
    repeat (3) begin tick(); cyc++; end
    check("restart_j", {24'd0, s_address}, 32'd1);
    wait_done(600, c);
    check("restart_cycles", cyc + c, 32'd417);
    check("restart_fail", {31'd0, fail}, 32'd0);
    start = 1'b0;
    tick();

    check("no_dual_write", {31'd0, both_seen}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/rc4_decrypt.md
Name: rc4_decrypt

Overview:
- Third stage of the RC4 datapath: runs the PRGA over a key-scheduled S memory after the shuffle (KSA) stage signals done.
- Each keystream byte is XORed with the encrypted message ROM. The plaintext is written to the decrypted-message RAM.
- Each byte is checked against lowercase/space. An invalid byte aborts the run so a key-search controller can move on.

Parameters:
MSG_LEN, 32, number of message bytes processed (1..256)
MSG_AW, 5, address width of encrypted ROM / decrypted RAM (2^MSG_AW >= MSG_LEN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level request; sampled only in IDLE
s_q  in  8  S memory read data
e_q  in  8  encrypted ROM read data
s_address  out  8  S memory address
s_data  out  8  S memory write data
s_write  out  1  S memory write enable
e_address  out  MSG_AW  encrypted ROM address
d_address  out  MSG_AW  decrypted RAM address
d_data  out  8  decrypted RAM write data
d_write  out  1  decrypted RAM write enable
done  out  1  run finished (pass or fail)
fail  out  1  valid with done; 1 = non-printable byte found

Behaviour:
- Reset (async, active-high):
  - State is IDLE. i, j, k, si, sj and f are 0.
  - All addresses and write data are 0.
  - s_write, d_write, done and fail are 0.
  - Reset mid-run abandons the run immediately; no further writes are issued.
- Memory timing: all memories are synchronous-read.
  - Address is driven in an RD state.
  - A WAIT state follows.
  - q is captured in the CAP state, two cycles after the address was first driven.
  - Writes complete on the edge ending the WR state.
- 8-bit arithmetic wraps mod 256: i, j, the i+1 increment and si+sj.
- k counts 0..MSG_LEN-1. e_address and d_address equal k at all times outside IDLE.
- State machine, one state per cycle:
  - IDLE: done=0. If start, clear i, j, k and fail, then go to INC.
  - INC: i <= i+1.
  - RD_I: s_address=i.
  - WAIT_I.
  - CAP_I: si <= s_q; j <= j+s_q.
  - RD_J: s_address=j.
  - WAIT_J.
  - CAP_J: sj <= s_q.
  - WR_I: s_address=i, s_data=sj, s_write=1.
  - WR_J: s_address=j, s_data=si, s_write=1.
  - RD_F: s_address=si+sj, using the captured values.
  - WAIT_F.
  - CAP_F: f <= s_q ^ e_q. e_q is stable because e_address=k throughout.
  - WR_D: d_data=f, d_write=1.
    - If f is not 8'h20 and not in 8'h61..8'h7A: fail <= 1 and go to DONE.
    - Else if k==MSG_LEN-1, go to DONE.
    - Else k <= k+1 and go to INC.
  - DONE: done=1, fail holds. Stay while start=1; go to IDLE when start=0.
- Per-byte latency: 13 cycles. Full pass of MSG_LEN bytes: 13*MSG_LEN + 1 cycles from start to done.
- i==j, including the first byte with identity S: both swap writes are issued and the memory is unchanged. This case is legal and needs no special handling.
- s_write and d_write are never asserted in the same cycle. At most one write strobe is high per cycle.
- The failing byte is still written to decrypted RAM before abort.
- start dropping mid-run is ignored; the run completes.
- done is never high outside DONE.

Test Plan:
- Identity S (s[i]=i), enc[0]=8'h63:
  - i=1, j=1, keystream 8'h02.
  - dec[0]=8'h61; s[1] unchanged; first d_write 13 cycles after start.
- Identity S, enc[1]=8'h65:
  - keystream 8'h05, dec[1]=8'h60.
  - fail=1, done=1 after exactly 2 bytes.
  - S memory shows s[2]=3, s[3]=2.
- Identity S, enc[k] = keystream XOR 8'h61 for all 32 bytes (keystream from a reference model):
  - done after 417 cycles, fail=0.
  - All dec bytes = 8'h61.
  - S memory matches the model.
- Byte 31 = 8'h20 (space) and byte 31 = 8'h7B in two separate runs: first passes, second gives fail=1 with 32 writes.
- Reset asserted during WR_I of byte 5:
  - All outputs return to 0 in the same cycle, no further s_write.
  - Re-issuing start restarts with i=1, j=0.
- start held high after done: done stays 1. Deassert start for 1 cycle then reassert: a new run begins and done falls.
